// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte-lane / word geometry used by the packer and the top.
package m_imem_loader_pkg;

  localparam int LANE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/m_imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: a 2-bit lane counter steers each accepted
// byte into its lane of the assembly register; word_full flags the 4th byte.
module m_byte_packer
  import m_imem_loader_pkg::*;
(
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              clr,
  input  logic              take,
  input  logic [LANE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (take) begin
      for (int k = 0; k < LANES; k++) begin
        if (cnt_q == 2'(k)) word_d[k*LANE_W +: LANE_W] = byte_in;
      end
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Lane 3 landing completes the word; the FSM moves to WRITE on the same edge.
  assign word_full = take && !clr && (cnt_q == 2'd3);
  assign word      = word_q;

endmodule

// File: rtl/m_imem_loader.sv
// Instruction-memory loader: packs a byte stream into 32-bit words, writes one
// word per WRITE cycle, and releases the CPU only once the whole image is in.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_start,
  input  logic [15:0]       w_nwords,
  input  logic              w_in_valid,
  input  logic [LANE_W-1:0] w_in_data,
  output logic              w_in_ready,
  output logic              w_we,
  output logic [WORD_W-1:0] w_waddr,
  output logic [WORD_W-1:0] w_wdata,
  output logic              w_busy,
  output logic              w_done,
  output logic              w_err,
  output logic              w_cpu_run,
  output logic [WORD_W-1:0] w_checksum
);

  state_e            state_q, state_d;
  logic [15:0]       nwords_q, nwords_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] checksum_q, checksum_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_run_q, cpu_run_d;

  logic              take;
  logic              pack_clr;
  logic              word_full;
  logic [WORD_W-1:0] pack_word;
  logic              len_bad;
  logic [15:0]       wcnt_inc;

  assign take     = w_in_valid && in_ready_q;
  assign len_bad  = (w_nwords == 16'd0) || ({16'd0, w_nwords} > 32'(WORDS));
  assign wcnt_inc = wcnt_q + 16'd1;

  m_byte_packer u_packer (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .clr       (pack_clr),
    .take      (take),
    .byte_in   (w_in_data),
    .word      (pack_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    nwords_d   = nwords_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    checksum_d = checksum_q;
    in_ready_d = in_ready_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_run_d  = cpu_run_q;
    pack_clr   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start) begin
          pack_clr   = 1'b1;
          nwords_d   = w_nwords;
          wcnt_d     = 16'd0;
          waddr_d    = BASE_ADDR;
          checksum_d = '0;
          done_d     = 1'b0;
          cpu_run_d  = 1'b0;
          if (len_bad) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
          end else begin
            state_d    = ST_LOAD;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (word_full) begin
          state_d    = ST_WRITE;
          in_ready_d = 1'b0;
          we_d       = 1'b1;
        end
      end

      ST_WRITE: begin
        checksum_d = checksum_q + pack_word;
        wcnt_d     = wcnt_inc;
        // The address only advances when another word follows, so it never
        // points past the last word of the image.
        if (wcnt_inc == nwords_q) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          cpu_run_d  = 1'b1;
          busy_d     = 1'b0;
          in_ready_d = 1'b0;
        end else begin
          state_d    = ST_LOAD;
          in_ready_d = 1'b1;
          waddr_d    = waddr_q + 32'd4;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= ST_IDLE;
      nwords_q   <= 16'd0;
      wcnt_q     <= 16'd0;
      waddr_q    <= BASE_ADDR;
      checksum_q <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nwords_q   <= nwords_d;
      wcnt_q     <= wcnt_d;
      waddr_q    <= waddr_d;
      checksum_q <= checksum_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_run_q  <= cpu_run_d;
    end
  end

  assign w_in_ready = in_ready_q;
  assign w_we       = we_q;
  assign w_waddr    = waddr_q;
  assign w_wdata    = pack_word;
  assign w_busy     = busy_q;
  assign w_done     = done_q;
  assign w_err      = err_q;
  assign w_cpu_run  = cpu_run_q;
  assign w_checksum = checksum_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Scoreboard bench for m_imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every w_we cycle.
module tb_m_imem_loader;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_start = 1'b0;
  logic [15:0] w_nwords = 16'd0;
  logic        w_in_valid = 1'b0;
  logic [7:0]  w_in_data = 8'd0;
  logic        w_in_ready;
  logic        w_we;
  logic [31:0] w_waddr;
  logic [31:0] w_wdata;
  logic        w_busy;
  logic        w_done;
  logic        w_err;
  logic        w_cpu_run;
  logic [31:0] w_checksum;

  m_imem_loader #(.WORDS(64), .BASE_ADDR(32'h0)) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_start    (w_start),
    .w_nwords   (w_nwords),
    .w_in_valid (w_in_valid),
    .w_in_data  (w_in_data),
    .w_in_ready (w_in_ready),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_busy     (w_busy),
    .w_done     (w_done),
    .w_err      (w_err),
    .w_cpu_run  (w_cpu_run),
    .w_checksum (w_checksum)
  );

  always #5 w_clk = ~w_clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out, got no response, expected one", name);
  endtask

  // Monitor: every write must match the head of the expected-write queue.
  always @(negedge w_clk) begin
    if (w_rst_n && w_we) begin
      if (exp_addr.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        chk("waddr", w_waddr, exp_addr.pop_front());
        chk("wdata", w_wdata, exp_data.pop_front());
        chk("ready_in_write", {31'd0, w_in_ready}, 32'd0);
      end
    end
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic do_start(input logic [15:0] n);
    w_start  = 1'b1;
    w_nwords = n;
    @(posedge w_clk); #1;
    w_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    w_in_valid = 1'b1;
    w_in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge w_clk);
      if (w_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    if (!ok) timeout("byte_handshake");
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[k*8 +: 8]);
      repeat (gap) begin
        @(posedge w_clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge w_clk);
      if (w_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_done");
    chk("cpu_run_at_done", {31'd0, w_cpu_run}, 32'd1);
    chk("busy_at_done", {31'd0, w_busy}, 32'd0);
    chk("ready_at_done", {31'd0, w_in_ready}, 32'd0);
    @(posedge w_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, visible before any clock edge.
    #3;
    chk("rst_ready", {31'd0, w_in_ready}, 32'd0);
    chk("rst_we", {31'd0, w_we}, 32'd0);
    chk("rst_busy", {31'd0, w_busy}, 32'd0);
    chk("rst_done", {31'd0, w_done}, 32'd0);
    chk("rst_err", {31'd0, w_err}, 32'd0);
    chk("rst_cpu_run", {31'd0, w_cpu_run}, 32'd0);
    chk("rst_waddr", w_waddr, 32'h0);
    chk("rst_wdata", w_wdata, 32'h0);
    chk("rst_checksum", w_checksum, 32'h0);
    @(posedge w_clk); @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    @(posedge w_clk); #1;

    // Basic load, valid held high.
    expect_write(32'h0, 32'h0000_0013);
    expect_write(32'h4, 32'h0010_0093);
    do_start(16'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done(20);
    chk("basic_checksum", w_checksum, 32'h0010_00A6);
    chk("basic_last_waddr", w_waddr, 32'h4);

    // Same image with valid gaps; start from DONE clears status next cycle.
    expect_write(32'h0, 32'h0000_0013);
    expect_write(32'h4, 32'h0010_0093);
    do_start(16'd2);
    @(negedge w_clk);
    chk("restart_done", {31'd0, w_done}, 32'd0);
    chk("restart_cpu_run", {31'd0, w_cpu_run}, 32'd0);
    chk("restart_checksum", w_checksum, 32'h0);
    chk("restart_waddr", w_waddr, 32'h0);
    chk("restart_busy", {31'd0, w_busy}, 32'd1);
    @(posedge w_clk); #1;
    send_word(32'h0000_0013, 2);
    send_word(32'h0010_0093, 1);
    wait_done(20);
    chk("gap_checksum", w_checksum, 32'h0010_00A6);

    // Illegal lengths, then recovery.
    do_start(16'd0);
    w_in_valid = 1'b1;
    w_in_data  = 8'h55;
    @(negedge w_clk);
    chk("err_zero", {31'd0, w_err}, 32'd1);
    chk("err_zero_busy", {31'd0, w_busy}, 32'd0);
    repeat (3) @(negedge w_clk);
    chk("err_zero_ready", {31'd0, w_in_ready}, 32'd0);
    @(posedge w_clk); #1;
    w_in_valid = 1'b0;
    do_start(16'd65);
    @(negedge w_clk);
    chk("err_65", {31'd0, w_err}, 32'd1);
    chk("err_65_ready", {31'd0, w_in_ready}, 32'd0);
    @(posedge w_clk); #1;
    expect_write(32'h0, 32'hAABB_CCDD);
    do_start(16'd1);
    @(negedge w_clk);
    chk("err_cleared", {31'd0, w_err}, 32'd0);
    chk("err_recover_busy", {31'd0, w_busy}, 32'd1);
    @(posedge w_clk); #1;
    send_word(32'hAABB_CCDD, 0);
    wait_done(20);
    chk("recover_checksum", w_checksum, 32'hAABB_CCDD);

    // Asynchronous reset after two bytes; stale bytes must not leak.
    do_start(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    w_rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", {31'd0, w_in_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, w_busy}, 32'd0);
    chk("mid_rst_wdata", w_wdata, 32'h0);
    chk("mid_rst_waddr", w_waddr, 32'h0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    @(posedge w_clk); #1;
    expect_write(32'h0, 32'h0000_006F);
    do_start(16'd1);
    send_word(32'h0000_006F, 0);
    wait_done(20);
    chk("post_rst_checksum", w_checksum, 32'h0000_006F);

    // start mid-LOAD is ignored.
    expect_write(32'h0, 32'h0403_0201);
    expect_write(32'h4, 32'h0807_0605);
    do_start(16'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    do_start(16'd1);
    @(negedge w_clk);
    chk("ignored_start_busy", {31'd0, w_busy}, 32'd1);
    @(posedge w_clk); #1;
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h0807_0605, 0);
    wait_done(20);
    chk("ignored_start_checksum", w_checksum, 32'h0C0A_0806);

    // Full 64-word fill: word i = 0x10000000 + i.
    for (int i = 0; i < 64; i++) expect_write(32'(4 * i), 32'h1000_0000 + 32'(i));
    do_start(16'd64);
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i), 0);
    wait_done(20);
    chk("full_last_waddr", w_waddr, 32'h0000_00FC);
    chk("full_checksum", w_checksum, 32'h0000_07E0);

    repeat (3) @(posedge w_clk);
    #1;
    chk("writes_outstanding", 32'(exp_addr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
